// File: rtl/add16_seq.sv
// Nibble-serial adder: one 4-bit ripple-carry slice reused over NIB cycles, LSB nibble first.
// The result is published on the edge that enters the one-cycle DONE state.
module add16_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] sum,
    output logic             cout
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  part_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q;

    int            sh;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    slice_sum;
    logic [4:0]    chain;
    logic          slice_cout;
    logic [W-1:0]  part_nxt;

    // Shared 4-bit ripple slice operating on nibble cnt_q of the latched operands.
    always_comb begin
        sh        = 4 * int'(cnt_q);
        nib_a     = 4'(a_q >> sh);
        nib_b     = 4'(b_q >> sh);
        chain     = '0;
        slice_sum = '0;
        chain[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = nib_a[i] ^ nib_b[i] ^ chain[i];
            chain[i+1]   = (nib_a[i] & nib_b[i]) | (chain[i] & (nib_a[i] ^ nib_b[i]));
        end
        slice_cout = chain[4];
        part_nxt   = (part_q & ~(W'(4'hF) << sh)) | (W'(slice_sum) << sh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        part_q  <= '0;
                        state_q <= StRun;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StRun: begin
                    part_q  <= part_nxt;
                    carry_q <= slice_cout;
                    if (cnt_q == LAST) begin
                        sum     <= part_nxt;
                        cout    <= slice_cout;
                        cnt_q   <= '0;
                        state_q <= StDone;
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/add16_seq.md
ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001 Parameter NIB, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new addition; sampled on clk rising edge.
REQ-005 a  input  W  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  W  operand B; sampled only on the edge that accepts start.
REQ-007 cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 ready  output  1  high when start will be accepted.
REQ-009 busy  output  1  high while nibble additions are in progress.
REQ-010 done  output  1  one-cycle pulse; sum and cout are valid.
REQ-011 sum  output  W  result; registered and held until the next done.
REQ-012 cout  output  1  final carry-out; registered and held with sum.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin by reusing one 4-bit ripple-carry slice (a chain of four full adders) over NIB cycles, processing the LSB nibble first.
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 IDLE: ready=1, busy=0, done=0; start=1 -> latch a, b and cin, clear the nibble counter, go to RUN.
REQ-016 RUN: ready=0, busy=1; each cycle, add nibble k of A, nibble k of B and the carry register, store the 4-bit result into nibble k of an internal partial register, store the slice carry into the carry register, and increment k.
REQ-017 RUN: when k = NIB-1 is processed, copy the partial register to sum and the slice carry to cout on that same edge, then go to DONE.
REQ-018 DONE lasts exactly one cycle: done=1, ready=1, busy=0.
REQ-019 DONE: start=1 -> accept new operands and go to RUN (back-to-back operation); otherwise go to IDLE.
REQ-020 Latency: start accepted at edge E0 -> done=1 during the cycle following edge E(NIB); a new result every NIB+1 cycles.
REQ-021 start in RUN SHALL be ignored and SHALL NOT disturb the latched operands, the counter or the carry register.
REQ-022 Changes on a, b or cin outside the accepting edge SHALL NOT affect the result.
REQ-023 sum and cout SHALL change only on the edge that enters DONE; they are never partially updated.
REQ-024 The nibble counter SHALL be ceil(log2(NIB)) bits wide (minimum 1) and SHALL wrap only by returning to IDLE or DONE.
REQ-025 Arithmetic is unsigned modulo 2^W; overflow is reported only through cout.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, with ready=1, busy=0, done=0, sum=0, cout=0, and the counter, carry register, partial register and latched operands all 0.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts behaves as if from power-up.

Verification
REQ-028 a=0x0000, b=0x0001, cin=0, one start pulse -> done once, 5 cycles after start, with sum=0x0001, cout=0.
REQ-029 a=0x0005, b=0x0003, cin=0 -> sum=0x0008, cout=0; then a=0x0F0F, b=0x00F1, cin=1 -> sum=0x1001, cout=0 (inter-nibble carry ripple).
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-031 start held high continuously with a=0x1234, b=0x1111 -> done every 5 cycles with sum=0x2345; operands changed during RUN do not alter the in-flight result.
REQ-032 rst pulsed during the 2nd RUN cycle of a=0x8888+b=0x8888 -> no done pulse, outputs 0, ready=1; a subsequent start with the same operands -> sum=0x1110, cout=1.
